alu_multicycle: RTL and testbench

- Execution-stage ALU that consumes the 6-bit funct code produced by the ALU control decoder.
- Add, subtract and set-less-than complete in one cycle. SLL and SLLV use an iterative shifter that moves one bit per cycle.
- Uses a start/busy/done handshake so the multi-cycle datapath controller can stall on long shifts.
- Sits between the ALU control decoder and the register-file writeback path.

---
 rtl/alu_multicycle_if.sv | 26 ++
 rtl/alu_multicycle.sv | 128 ++++++++++++
 tb/tb_alu_multicycle.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Start/busy/done handshake bundle between the datapath controller and alu_multicycle.
interface alu_multicycle_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;
    logic             illegal;

    modport master (
        output start, funct, src1, src2, shamt,
        input  result, zero, busy, done, illegal
    );

    modport slave (
        input  start, funct, src1, src2, shamt,
        output result, zero, busy, done, illegal
    );
endinterface

// File: rtl/alu_multicycle.sv
// Execution-stage ALU: single-cycle ADD/SUB/SLT, bit-serial SLL/SLLV,
// with a start/busy/done handshake so the controller can stall on shifts.
module alu_multicycle #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    alu_multicycle_if.slave   bus
);
    localparam logic [5:0] F_ADD  = 6'b001001;
    localparam logic [5:0] F_SUB  = 6'b001010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLL  = 6'b100001;
    localparam logic [5:0] F_SLLV = 6'b110101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;
    logic             illegal_q;

    logic [WIDTH-1:0] alu_res_c;
    logic [SHW-1:0]   amt_c;
    logic             shift_op_c;
    logic             illegal_op_c;

    // Decode the presented funct; only consulted on the accepting edge in IDLE.
    always_comb begin
        alu_res_c    = '0;
        amt_c        = '0;
        shift_op_c   = 1'b0;
        illegal_op_c = 1'b0;
        unique case (bus.funct)
            F_ADD:   alu_res_c = bus.src1 + bus.src2;
            F_SUB:   alu_res_c = bus.src1 - bus.src2;
            F_SLT:   alu_res_c = WIDTH'($signed(bus.src1) < $signed(bus.src2));
            F_SLL: begin
                shift_op_c = 1'b1;
                amt_c      = bus.shamt;
            end
            F_SLLV: begin
                shift_op_c = 1'b1;
                amt_c      = bus.src1[SHW-1:0];
            end
            default: illegal_op_c = 1'b1;
        endcase
    end

    // Control FSM and datapath; every output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            cnt       <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (shift_op_c) begin
                            acc <= bus.src2;
                            cnt <= amt_c;
                            if (amt_c != '0) begin
                                state <= S_SHIFT;
                            end else begin
                                result_q <= bus.src2;
                                zero_q   <= (bus.src2 == '0);
                                done_q   <= 1'b1;
                                state    <= S_DONE;
                            end
                        end else begin
                            result_q  <= alu_res_c;
                            zero_q    <= (alu_res_c == '0);
                            illegal_q <= illegal_op_c;
                            done_q    <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                // One bit per edge; the edge that finds the counter at zero retires the result.
                S_SHIFT: begin
                    if (cnt == '0) begin
                        result_q <= acc;
                        zero_q   <= (acc == '0);
                        done_q   <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        acc <= {acc[WIDTH-2:0], 1'b0};
                        cnt <= cnt - SHW'(1);
                    end
                end
                S_DONE: begin
                    done_q    <= 1'b0;
                    illegal_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    done_q    <= 1'b0;
                    illegal_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.result  = result_q;
    assign bus.zero    = zero_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle with hand-computed expectations.
module tb_alu_multicycle;
    localparam logic [5:0] F_ADD  = 6'b001001;
    localparam logic [5:0] F_SUB  = 6'b001010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLL  = 6'b100001;
    localparam logic [5:0] F_SLLV = 6'b110101;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    alu_multicycle_if #(.WIDTH(32), .SHW(5)) bus ();

    alu_multicycle #(.WIDTH(32), .SHW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, then wait (bounded) for done; lat counts cycles after the accepting edge.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, output int lat, output int busy_cyc,
                          output logic ill);
        @(negedge clk);
        bus.funct = f;
        bus.src1  = a;
        bus.src2  = b;
        bus.shamt = sh;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        ill      = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = c;
                ill = bus.illegal;
                break;
            end
            if (bus.busy) busy_cyc++;
        end
    endtask

    initial begin
        int   lat;
        int   bc;
        int   nd;
        logic ill;

        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.funct = '0;
        bus.src1  = '0;
        bus.src2  = '0;
        bus.shamt = '0;

        #1;
        check("rst_result",  bus.result, 32'h0);
        check("rst_zero",    32'(bus.zero), 32'd1);
        check("rst_busy",    32'(bus.busy), 32'd0);
        check("rst_done",    32'(bus.done), 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(F_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, lat, bc, ill);
        check("add_lat",    32'(lat), 32'd1);
        check("add_result", bus.result, 32'h8000_0000);
        check("add_zero",   32'(bus.zero), 32'd0);
        check("add_busy",   32'(bus.busy), 32'd1);

        run_op(F_ADD, 32'h7FFF_FFFF, 32'h8000_0001, 5'd0, lat, bc, ill);
        check("addw_result", bus.result, 32'h0000_0000);
        check("addw_zero",   32'(bus.zero), 32'd1);

        run_op(F_SUB, 32'd5, 32'd7, 5'd0, lat, bc, ill);
        check("sub_result", bus.result, 32'hFFFF_FFFE);
        check("sub_zero",   32'(bus.zero), 32'd0);

        run_op(F_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, lat, bc, ill);
        check("slt_neg_result", bus.result, 32'h0000_0001);

        run_op(F_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, lat, bc, ill);
        check("slt_pos_result", bus.result, 32'h0000_0000);
        check("slt_pos_zero",   32'(bus.zero), 32'd1);

        run_op(F_SLL, 32'h0, 32'h0000_0003, 5'd4, lat, bc, ill);
        check("sll4_lat",    32'(lat), 32'd6);
        check("sll4_busy",   32'(bc), 32'd5);
        check("sll4_result", bus.result, 32'h0000_0030);

        run_op(F_SLL, 32'h0, 32'hABCD_1234, 5'd0, lat, bc, ill);
        check("sll0_lat",    32'(lat), 32'd1);
        check("sll0_result", bus.result, 32'hABCD_1234);

        run_op(F_SLLV, 32'h0000_003F, 32'h0000_0001, 5'd0, lat, bc, ill);
        check("sllv31_lat",    32'(lat), 32'd33);
        check("sllv31_result", bus.result, 32'h8000_0000);

        // Start pulses during SHIFT and DONE must be dropped; operands were latched.
        @(negedge clk);
        bus.funct = F_SLL;
        bus.src1  = 32'h0;
        bus.src2  = 32'h0000_0003;
        bus.shamt = 5'd4;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.funct = F_ADD;
        bus.src1  = 32'h100;
        bus.src2  = 32'h200;
        bus.shamt = 5'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        for (int c = 4; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        check("ign_lat",    32'(lat), 32'd6);
        check("ign_result", bus.result, 32'h0000_0030);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check("ign_extra_done", 32'(nd), 32'd0);
        check("ign_hold",       bus.result, 32'h0000_0030);

        run_op(6'b000000, 32'h1234, 32'h5678, 5'd3, lat, bc, ill);
        check("ill_lat",     32'(lat), 32'd1);
        check("ill_flag",    32'(ill), 32'd1);
        check("ill_result",  bus.result, 32'h0);
        check("ill_zero",    32'(bus.zero), 32'd1);

        run_op(F_ADD, 32'd2, 32'd3, 5'd0, lat, bc, ill);
        check("post_ill_flag",   32'(ill), 32'd0);
        check("post_ill_result", bus.result, 32'd5);

        // Start held high: single-cycle ops retire every other cycle.
        @(negedge clk);
        bus.funct = F_ADD;
        bus.src1  = 32'd1;
        bus.src2  = 32'd1;
        bus.start = 1'b1;
        nd = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        bus.start = 1'b0;
        check("b2b_dones",  32'(nd), 32'd3);
        check("b2b_result", bus.result, 32'd2);

        // Asynchronous reset in the middle of a 20-step SLLV.
        @(negedge clk);
        bus.funct = F_SLLV;
        bus.src1  = 32'd20;
        bus.src2  = 32'd1;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",   32'(bus.busy), 32'd0);
        check("mid_rst_result", bus.result, 32'h0);
        check("mid_rst_zero",   32'(bus.zero), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check("mid_rst_no_done", 32'(nd), 32'd0);

        run_op(F_ADD, 32'd10, 32'd20, 5'd0, lat, bc, ill);
        check("post_rst_lat",    32'(lat), 32'd1);
        check("post_rst_result", bus.result, 32'd30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
